rr_arbiter_onehot: RTL and testbench
====================================

Name: rr_arbiter_onehot

Overview:
- Round-robin arbiter with lock support. Produces a one-hot grant vector from NUM_REQS request lines.
- Sits directly upstream of encoder_onehot. It drives o__grant into the encoder's i__onehot input, and the encoder's o__encode selects the winning port in the router/crossbar.
- The grant is guaranteed zero-hot or one-hot, so the downstream encoder never sees an illegal pattern.

Parameters:
- NUM_REQS, 4, number of requesters (must be ≥1; 2/4/6/8/11 match encoder fast paths).
- LOG_NUM_REQS, $clog2(NUM_REQS), width of internal index arithmetic (minimum 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- i__request  input  NUM_REQS  per-requester request, level-sensitive.
- i__accept  input  1  downstream consumed the current grant this cycle; ignored when o__grant_valid=0.
- i__lock  input  1  sampled with an accepted grant; holds the grant on that requester for following cycles.
- o__grant  output  NUM_REQS  one-hot grant, or all-zero when there is no grant.
- o__grant_valid  output  1  OR-reduction of o__grant.

Behaviour:
- State:
  - prio: one-hot NUM_REQS-bit priority pointer; reset value 'b1 (bit 0).
  - st: ARB or LOCKED; reset value ARB.
  - lock_vec: NUM_REQS bits; reset value 0.
- Outputs are combinational from state and i__request. While reset=1, o__grant=0 and o__grant_valid=0 regardless of other inputs.
- ARB grant selection:
  - Grant the first set bit of i__request scanning upward from the prio position, wrapping from bit NUM_REQS-1 to bit 0.
  - If i__request=0, then o__grant=0.
  - No latency: a request appearing in cycle t can be granted in cycle t.
- LOCKED grant selection:
  - If (lock_vec & i__request) != 0, o__grant = lock_vec.
  - Otherwise the lock is broken: o__grant uses the ARB selection in the same cycle, and st returns to ARB next cycle.
- Handshake: a grant is "taken" on a rising edge where o__grant_valid=1 and i__accept=1. With no accept, o__grant may change if requests change; the arbiter keeps no memory of an unaccepted grant.
- Pointer update:
  - On a taken grant at index k where the next state is ARB, prio <= bit (k+1) mod NUM_REQS, i.e. rotate-left of o__grant by 1.
  - On a taken grant that enters or stays in LOCKED, prio is unchanged.
  - With no taken grant, prio holds.
- Transitions:
  - ARB -> LOCKED: taken grant with i__lock=1; lock_vec <= o__grant.
  - LOCKED -> LOCKED: taken grant with i__lock=1, or no taken grant while the locked request is still high.
  - LOCKED -> ARB (normal release): taken grant with i__lock=0; lock_vec <= 0; prio <= rotate-left(lock_vec,1).
  - LOCKED -> ARB (lock broken): locked request deasserted; lock_vec <= 0. prio updates only if the fallback grant is taken, and then per the pointer-update rule.
- Reset mid-operation: reset overrides every transition; a LOCKED state is discarded without a grant.
- NUM_REQS=1: o__grant = i__request[0]; prio is constant; the lock logic still operates but is observably transparent.
- Invariants (bench assertions):
  - $onehot0(o__grant).
  - o__grant is a subset of i__request.
  - prio is always one-hot.
  - lock_vec is nonzero exactly when st==LOCKED.

Decomposition:
- Shared package (interconnect_pkg or the existing common package):
  - typedef enum logic {ARB, LOCKED} arb_state_t.
  - A rotate-left-by-one function on a parameterised vector.
- Sub-module rr_priority_select (combinational):
  - Inputs: request vector and one-hot prio.
  - Output: one-hot pick.
  - Implementation: double-width (request,request) minus prio masking, or a masked/unmasked two-level priority pick.
  - Reusable by other arbiters in the codebase.

Test Plan (NUM_REQS=4):
- Reset, then i__request=4'b1111 with i__accept=1 every cycle -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; valid=1 throughout.
- prio at bit 2 (after accepting bit 1), i__request=4'b0011 -> o__grant=0001 (wrap); after accept, prio=bit 1.
- i__request=4'b0110 with i__accept=0 for 3 cycles -> o__grant stays 0010 and prio is unchanged; then accept -> next grant 0100.
- Lock then release:
  - Accept the grant 0010 with i__lock=1 while i__request=1111 -> the next 3 cycles grant 0010 even with accepts.
  - An accept with i__lock=0 releases the lock -> the next grant is 0100.
- Lock broken: while LOCKED on 0100, drop request bit 2 with i__request=1011 -> the same cycle grants 1000 via ARB from the unchanged prio; st=ARB next cycle.
- Assert reset for one cycle while LOCKED with requests pending -> o__grant=0 during reset; afterwards prio=bit 0 and, with i__request=1111, o__grant=0001.

Source files
------------

// File: rtl/rr_arbiter_onehot_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter family.
`default_nettype none

package rr_arbiter_onehot_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Widest vector the rotate helper supports; callers zero-extend into it.
  localparam int MAX_REQS = 64;

  // Rotate the low n bits of v left by one; bits at and above n must be zero.
  function automatic logic [MAX_REQS-1:0] rotl1(input logic [MAX_REQS-1:0] v,
                                                input int unsigned n);
    logic [MAX_REQS-1:0] mask;
    mask = (n >= MAX_REQS) ? '1 : ((MAX_REQS'(1) << n) - MAX_REQS'(1));
    return ((v << 1) | (v >> (n - 1))) & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_select.sv
// Combinational pick of the first set request at or above a one-hot priority, wrapping.
`default_nettype none

module rr_priority_select #(
  parameter int NUM_REQS = 4
) (
  input  logic [NUM_REQS-1:0] i_request,
  input  logic [NUM_REQS-1:0] i_prio,
  output logic [NUM_REQS-1:0] o_pick
);

  logic [2*NUM_REQS-1:0] w_double;
  logic [2*NUM_REQS-1:0] w_borrow;
  logic [2*NUM_REQS-1:0] w_lowest;

  // Subtracting prio from {req,req} clears the first set bit at/above prio and
  // flips nothing below it; the bit that changed 1->0 is the winner.
  assign w_double = {i_request, i_request};
  assign w_borrow = w_double - {{NUM_REQS{1'b0}}, i_prio};
  assign w_lowest = w_double & ~w_borrow;
  assign o_pick   = w_lowest[NUM_REQS-1:0] | w_lowest[2*NUM_REQS-1:NUM_REQS];

endmodule

`default_nettype wire

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with grant lock; drives a zero/one-hot grant into encoder_onehot.
`default_nettype none

module rr_arbiter_onehot
  import rr_arbiter_onehot_pkg::*;
#(
  parameter int NUM_REQS     = 4,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] i__request,
  input  logic                i__accept,
  input  logic                i__lock,
  output logic [NUM_REQS-1:0] o__grant,
  output logic                o__grant_valid
);

  if (NUM_REQS < 1 || NUM_REQS > MAX_REQS || LOG_NUM_REQS < 1) begin : g_param_check
    $error("rr_arbiter_onehot: NUM_REQS out of range");
  end

  arb_state_t          r_st;
  arb_state_t          w_st_nxt;
  logic [NUM_REQS-1:0] r_prio;
  logic [NUM_REQS-1:0] w_prio_nxt;
  logic [NUM_REQS-1:0] r_lock_vec;
  logic [NUM_REQS-1:0] w_lock_nxt;
  logic [NUM_REQS-1:0] w_arb_pick;
  logic [NUM_REQS-1:0] w_grant;
  logic [NUM_REQS-1:0] w_grant_rot;
  logic                w_lock_hit;
  logic                w_taken;

  rr_priority_select #(
    .NUM_REQS (NUM_REQS)
  ) u_select (
    .i_request (i__request),
    .i_prio    (r_prio),
    .o_pick    (w_arb_pick)
  );

  assign w_lock_hit = (r_st == LOCKED) && (|(r_lock_vec & i__request));

  // A broken lock falls straight back to the round-robin pick in the same cycle.
  assign w_grant = reset      ? '0 :
                   w_lock_hit ? r_lock_vec : w_arb_pick;

  assign o__grant       = w_grant;
  assign o__grant_valid = |w_grant;
  assign w_taken        = o__grant_valid & i__accept;
  assign w_grant_rot    = NUM_REQS'(rotl1(MAX_REQS'(w_grant), NUM_REQS));

  always_comb begin
    w_st_nxt   = r_st;
    w_prio_nxt = r_prio;
    w_lock_nxt = r_lock_vec;
    if ((r_st == LOCKED) && !w_lock_hit) begin
      w_st_nxt   = ARB;
      w_lock_nxt = '0;
    end
    if (w_taken) begin
      if (i__lock) begin
        // Entering or holding a lock leaves the pointer where it was.
        w_st_nxt   = LOCKED;
        w_lock_nxt = w_grant;
      end else begin
        w_st_nxt   = ARB;
        w_lock_nxt = '0;
        w_prio_nxt = w_grant_rot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st       <= ARB;
      r_prio     <= NUM_REQS'(1);
      r_lock_vec <= '0;
    end else begin
      r_st       <= w_st_nxt;
      r_prio     <= w_prio_nxt;
      r_lock_vec <= w_lock_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_onehot.sv
// Self-checking bench for rr_arbiter_onehot (NUM_REQS=4) with an expected-grant queue.
`default_nettype none

module tb_rr_arbiter_onehot;
  import rr_arbiter_onehot_pkg::*;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] i__request;
  logic         i__accept;
  logic         i__lock;
  logic [N-1:0] o__grant;
  logic         o__grant_valid;

  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_q[$];

  // Independent reference model state
  int           m_prio;
  bit           m_locked;
  logic [N-1:0] m_lockv;

  rr_arbiter_onehot #(
    .NUM_REQS (N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i__request     (i__request),
    .i__accept      (i__accept),
    .i__lock        (i__lock),
    .o__grant       (o__grant),
    .o__grant_valid (o__grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected finish");
    $fatal(1);
  end

  task automatic drive(input logic rst, input logic [N-1:0] req, input logic acc,
                       input logic lk, input logic [N-1:0] exp);
    @(posedge clk);
    #1;
    reset      = rst;
    i__request = req;
    i__accept  = acc;
    i__lock    = lk;
    exp_q.push_back(exp);
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] req);
    if (m_locked && ((m_lockv & req) != 0)) return m_lockv;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_prio + k) % N;
      if (req[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic test_reset();
    logic [N-1:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e || o__grant_valid !== (|e)) begin
        errors++;
        $display("FAIL reset_grant[%0d]: got %b/%b expected %b/%b", i, o__grant, o__grant_valid, e, |e);
      end
    end
    checks++;
    if (dut.r_prio !== 4'b0001 || dut.r_st !== ARB || dut.r_lock_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got prio=%b st=%0d lock=%b expected 0001/0/0000", dut.r_prio, dut.r_st, dut.r_lock_vec);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_t[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b1111, 1'b1, 1'b0, exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e || o__grant_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: got %b/%b expected %b/1", i, o__grant, o__grant_valid, e);
      end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] req_t[3] = '{4'b1111, 4'b0011, 4'b1111};
    logic         acc_t[3] = '{1'b1, 1'b1, 1'b0};
    logic [N-1:0] exp_t[3] = '{4'b0010, 4'b0001, 4'b0010};
    logic [N-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, req_t[i], acc_t[i], 1'b0, exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e) begin
        errors++;
        $display("FAIL wrap[%0d]: got %b expected %b", i, o__grant, e);
      end
    end
    checks++;
    if (dut.r_prio !== 4'b0010) begin
      errors++;
      $display("FAIL wrap_prio: got %b expected 0010", dut.r_prio);
    end
  endtask

  task automatic test_no_accept_hold();
    logic         acc_t[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] exp_t[5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic [N-1:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 4'b0110, acc_t[i], 1'b0, exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e) begin
        errors++;
        $display("FAIL hold[%0d]: got %b expected %b", i, o__grant, e);
      end
    end
  endtask

  task automatic test_lock_release();
    logic [N-1:0] req_t[7] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic         acc_t[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         lk_t[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [N-1:0] exp_t[7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    logic [N-1:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, req_t[i], acc_t[i], lk_t[i], exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e) begin
        errors++;
        $display("FAIL lock_release[%0d]: got %b expected %b", i, o__grant, e);
      end
    end
    checks++;
    if (dut.r_st !== ARB || dut.r_prio !== 4'b0100) begin
      errors++;
      $display("FAIL lock_release_state: got st=%0d prio=%b expected 0/0100", dut.r_st, dut.r_prio);
    end
  endtask

  task automatic test_lock_broken();
    logic [N-1:0] req_t[3] = '{4'b1111, 4'b1011, 4'b1011};
    logic         acc_t[3] = '{1'b1, 1'b0, 1'b0};
    logic         lk_t[3]  = '{1'b1, 1'b0, 1'b0};
    logic [N-1:0] exp_t[3] = '{4'b0100, 4'b1000, 4'b1000};
    logic [N-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, req_t[i], acc_t[i], lk_t[i], exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e) begin
        errors++;
        $display("FAIL lock_broken[%0d]: got %b expected %b", i, o__grant, e);
      end
      if (i == 1) begin
        checks++;
        if (dut.r_st !== LOCKED || dut.r_lock_vec !== 4'b0100) begin
          errors++;
          $display("FAIL lock_broken_locked: got st=%0d lock=%b expected 1/0100", dut.r_st, dut.r_lock_vec);
        end
      end
    end
    checks++;
    if (dut.r_st !== ARB || dut.r_lock_vec !== 4'b0000 || dut.r_prio !== 4'b0100) begin
      errors++;
      $display("FAIL lock_broken_state: got st=%0d lock=%b prio=%b expected 0/0000/0100",
               dut.r_st, dut.r_lock_vec, dut.r_prio);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic         rst_t[3] = '{1'b0, 1'b1, 1'b0};
    logic [N-1:0] exp_t[3] = '{4'b0100, 4'b0000, 4'b0001};
    logic         acc_t[3] = '{1'b1, 1'b1, 1'b0};
    logic [N-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(rst_t[i], 4'b1111, acc_t[i], 1'b1, exp_t[i]);
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e || o__grant_valid !== (|e)) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %b/%b expected %b/%b", i, o__grant, o__grant_valid, e, |e);
      end
    end
    checks++;
    if (dut.r_prio !== 4'b0001 || dut.r_st !== ARB) begin
      errors++;
      $display("FAIL reset_mid_state: got prio=%b st=%0d expected 0001/0", dut.r_prio, dut.r_st);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] req, e, g;
    logic         acc, lk;
    bit           taken, hit;
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    void'(exp_q.pop_front());
    m_prio = 0; m_locked = 0; m_lockv = '0;
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom_range(0, 15));
      acc = 1'($urandom_range(0, 1));
      lk  = ($urandom_range(0, 2) == 0);
      drive(1'b0, req, acc, lk, model_grant(req));
      e = exp_q.pop_front();
      checks++;
      if (o__grant !== e || o__grant_valid !== (|e)) begin
        errors++;
        $display("FAIL random[%0d]: req=%b got %b/%b expected %b/%b", i, req, o__grant, o__grant_valid, e, |e);
      end
      checks++;
      if (!$onehot0(o__grant) || ((o__grant & ~req) != 0) || !$onehot(dut.r_prio) ||
          ((dut.r_lock_vec != 0) !== (dut.r_st == LOCKED))) begin
        errors++;
        $display("FAIL invariant[%0d]: grant=%b req=%b prio=%b lock=%b st=%0d expected legal",
                 i, o__grant, req, dut.r_prio, dut.r_lock_vec, dut.r_st);
      end
      g     = e;
      taken = (g != 0) && acc;
      hit   = m_locked && ((m_lockv & req) != 0);
      if (!hit) begin
        m_locked = 0;
        m_lockv  = '0;
      end
      if (taken) begin
        if (lk) begin
          m_locked = 1;
          m_lockv  = g;
        end else begin
          m_locked = 0;
          m_lockv  = '0;
          m_prio   = (onehot_idx(g) + 1) % N;
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    i__request = '0;
    i__accept  = 1'b0;
    i__lock    = 1'b0;
    test_reset();
    test_rotation();
    test_wrap();
    test_no_accept_hold();
    test_lock_release();
    test_lock_broken();
    test_reset_mid_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
